// File: rtl/pb_edge_multi.sv
// pb_edge_multi: N-channel pushbutton conditioner producing a debounced level and
// single-cycle press / release / long-press / auto-repeat pulses per channel.
`default_nettype none

module pb_edge_multi #(
  parameter int N          = 4,
  parameter int SYNC       = 2,
  parameter int DEB_CNT    = 16,
  parameter int LONG_CNT   = 1000,
  parameter int REP_CNT    = 200,
  parameter int ACTIVE_LOW = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] pb,
  output logic [N-1:0] lvl,
  output logic [N-1:0] prss,
  output logic [N-1:0] rls,
  output logic [N-1:0] lng,
  output logic [N-1:0] rpt
);

  localparam int DW   = $clog2(DEB_CNT + 1);
  localparam int HMAX = (LONG_CNT > REP_CNT) ? LONG_CNT : REP_CNT;
  localparam int HW   = $clog2(HMAX + 1);

  localparam logic          AL        = (ACTIVE_LOW != 0);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CNT - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CNT - 1);
  localparam logic [HW-1:0] LONG_SAT  = HW'(LONG_CNT);
  localparam logic [HW-1:0] REP_LAST  = HW'((REP_CNT > 0) ? (REP_CNT - 1) : 0);

  typedef enum logic [1:0] {
    HOLD_IDLE = 2'd0,
    HOLD_WAIT = 2'd1,
    HOLD_REP  = 2'd2
  } hold_e;

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [SYNC-1:0] sync_q, sync_d;
    logic            s;
    logic            st_q, st_d;
    logic [DW-1:0]   dcnt_q, dcnt_d;
    logic            acc_press, acc_release;
    hold_e           hst_q, hst_d;
    logic [HW-1:0]   hcnt_q, hcnt_d;
    logic            prss_q, prss_d;
    logic            rls_q, rls_d;
    logic            lng_q, lng_d;
    logic            rpt_q, rpt_d;

    // Debounce: a level change is accepted only after DEB_CNT consecutive
    // disagreeing samples; any agreeing sample restarts the count.
    always_comb begin
      sync_d      = {sync_q[SYNC-2:0], pb[i]};
      s           = sync_q[SYNC-1] ^ AL;
      st_d        = st_q;
      dcnt_d      = dcnt_q;
      acc_press   = 1'b0;
      acc_release = 1'b0;
      if (s == st_q) begin
        dcnt_d = '0;
      end else if (dcnt_q == DEB_LAST) begin
        st_d        = s;
        dcnt_d      = '0;
        acc_press   = s;
        acc_release = ~s;
      end else begin
        dcnt_d = dcnt_q + DW'(1);
      end
    end

    // Release wins over any long/repeat pulse falling due in the same cycle.
    always_comb begin
      hst_d  = hst_q;
      hcnt_d = hcnt_q;
      lng_d  = 1'b0;
      rpt_d  = 1'b0;
      prss_d = acc_press;
      rls_d  = acc_release;
      if (acc_release) begin
        hst_d  = HOLD_IDLE;
        hcnt_d = '0;
      end else begin
        case (hst_q)
          HOLD_IDLE: begin
            if (acc_press) begin
              hst_d  = HOLD_WAIT;
              hcnt_d = '0;
            end
          end
          HOLD_WAIT: begin
            if (hcnt_q == LONG_LAST) begin
              lng_d = 1'b1;
              if (REP_CNT > 0) begin
                hst_d  = HOLD_REP;
                hcnt_d = '0;
              end else begin
                hcnt_d = LONG_SAT;
              end
            end else if (hcnt_q < LONG_SAT) begin
              hcnt_d = hcnt_q + HW'(1);
            end
          end
          HOLD_REP: begin
            if (hcnt_q == REP_LAST) begin
              rpt_d  = 1'b1;
              hcnt_d = '0;
            end else begin
              hcnt_d = hcnt_q + HW'(1);
            end
          end
          default: begin
            hst_d  = HOLD_IDLE;
            hcnt_d = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync_q <= {SYNC{AL}};
        st_q   <= 1'b0;
        dcnt_q <= '0;
        hst_q  <= HOLD_IDLE;
        hcnt_q <= '0;
        prss_q <= 1'b0;
        rls_q  <= 1'b0;
        lng_q  <= 1'b0;
        rpt_q  <= 1'b0;
      end else begin
        sync_q <= sync_d;
        st_q   <= st_d;
        dcnt_q <= dcnt_d;
        hst_q  <= hst_d;
        hcnt_q <= hcnt_d;
        prss_q <= prss_d;
        rls_q  <= rls_d;
        lng_q  <= lng_d;
        rpt_q  <= rpt_d;
      end
    end

    assign lvl[i]  = st_q;
    assign prss[i] = prss_q;
    assign rls[i]  = rls_q;
    assign lng[i]  = lng_q;
    assign rpt[i]  = rpt_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_pb_edge_multi.sv
// tb_pb_edge_multi: directed and random stimulus on two pb_edge_multi instances
// (repeat enabled / disabled) checked every cycle against an event-time model.
`default_nettype none

module tb_pb_edge_multi;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int REP0 = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] pb_r   [2];
  logic [3:0] lvl_w  [2];
  logic [3:0] prss_w [2];
  logic [3:0] rls_w  [2];
  logic [3:0] lng_w  [2];
  logic [3:0] rpt_w  [2];

  always #5 clk = ~clk;

  pb_edge_multi #(.N(4), .SYNC(SYNC), .DEB_CNT(DEB), .LONG_CNT(LONG), .REP_CNT(REP0), .ACTIVE_LOW(1)) u_dut0 (
    .clk(clk), .rst(rst), .pb(pb_r[0]),
    .lvl(lvl_w[0]), .prss(prss_w[0]), .rls(rls_w[0]), .lng(lng_w[0]), .rpt(rpt_w[0])
  );

  pb_edge_multi #(.N(4), .SYNC(SYNC), .DEB_CNT(DEB), .LONG_CNT(LONG), .REP_CNT(0), .ACTIVE_LOW(1)) u_dut1 (
    .clk(clk), .rst(rst), .pb(pb_r[1]),
    .lvl(lvl_w[1]), .prss(prss_w[1]), .rls(rls_w[1]), .lng(lng_w[1]), .rpt(rpt_w[1])
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model: per channel, remember when the synchronised sample last changed,
  // when the press was accepted, and derive every pulse from elapsed cycles.
  bit         pipe   [2][4][SYNC];
  bit         m_lvl  [2][4];
  bit         s_prev [2][4];
  bit         held   [2][4];
  int         since  [2][4];
  int         tp     [2][4];
  logic [3:0] e_lvl  [2];
  logic [3:0] e_prss [2];
  logic [3:0] e_rls  [2];
  logic [3:0] e_lng  [2];
  logic [3:0] e_rpt  [2];
  bit         ms;
  int         md;
  int         mrep;

  always @(posedge clk) begin
    cyc++;
    for (int u = 0; u < 2; u++) begin
      mrep      = (u == 0) ? REP0 : 0;
      e_prss[u] = '0;
      e_rls[u]  = '0;
      e_lng[u]  = '0;
      e_rpt[u]  = '0;
      for (int c = 0; c < 4; c++) begin
        if (!rst) begin
          for (int k = 0; k < SYNC; k++) pipe[u][c][k] = 1'b1;
          m_lvl[u][c]  = 1'b0;
          s_prev[u][c] = 1'b0;
          held[u][c]   = 1'b0;
          since[u][c]  = cyc;
          tp[u][c]     = 0;
        end else begin
          ms = ~pipe[u][c][0];
          for (int k = 0; k < SYNC - 1; k++) pipe[u][c][k] = pipe[u][c][k+1];
          pipe[u][c][SYNC-1] = pb_r[u][c];
          if (ms != s_prev[u][c]) begin
            s_prev[u][c] = ms;
            since[u][c]  = cyc;
          end
          if (ms != m_lvl[u][c] && (cyc - since[u][c] + 1) >= DEB) begin
            m_lvl[u][c] = ms;
            if (ms) begin
              e_prss[u][c] = 1'b1;
              held[u][c]   = 1'b1;
              tp[u][c]     = cyc;
            end else begin
              e_rls[u][c] = 1'b1;
              held[u][c]  = 1'b0;
            end
          end else if (held[u][c]) begin
            md = cyc - tp[u][c];
            if (md == LONG) e_lng[u][c] = 1'b1;
            if (mrep > 0 && md > LONG && ((md - LONG) % mrep) == 0) e_rpt[u][c] = 1'b1;
          end
        end
        e_lvl[u][c] = m_lvl[u][c];
      end
    end
  end

  // Event log of what the DUT actually produced, used by the literal checks.
  int cnt    [2][4][4];
  int last_t [2][4][4];
  int rpt_q  [$];
  logic [3:0] ov [4];
  logic [3:0] xv [5];
  logic [3:0] av [5];
  string      nm [5] = '{"lvl", "prss", "rls", "lng", "rpt"};

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      xv[0] = rst ? e_lvl[u]  : 4'h0;
      xv[1] = rst ? e_prss[u] : 4'h0;
      xv[2] = rst ? e_rls[u]  : 4'h0;
      xv[3] = rst ? e_lng[u]  : 4'h0;
      xv[4] = rst ? e_rpt[u]  : 4'h0;
      av[0] = lvl_w[u];
      av[1] = prss_w[u];
      av[2] = rls_w[u];
      av[3] = lng_w[u];
      av[4] = rpt_w[u];
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (av[k] !== xv[k]) begin
          failures++;
          $display("FAIL cmp_u%0d_%s cyc=%0d got=%h expected=%h", u, nm[k], cyc, av[k], xv[k]);
        end
      end
      if (rst) begin
        ov[0] = prss_w[u];
        ov[1] = rls_w[u];
        ov[2] = lng_w[u];
        ov[3] = rpt_w[u];
        for (int k = 0; k < 4; k++)
          for (int c = 0; c < 4; c++)
            if (ov[k][c] === 1'b1) begin
              cnt[u][k][c]++;
              last_t[u][k][c] = cyc;
              if (u == 0 && k == 3 && c == 2) rpt_q.push_back(cyc);
            end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // kind: 0 prss, 1 rls, 2 lng, 3 rpt. Returns -1000 on timeout so the
  // following latency check fails.
  task automatic wait_for(input int u, input int k, input int c, input int bound, output int t);
    int c0;
    c0 = cnt[u][k][c];
    t  = -1000;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      #1;
      if (cnt[u][k][c] != c0) begin
        t = last_t[u][k][c];
        break;
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int t, t0, t1, c0, total;
    pb_r[0] = 4'hF;
    pb_r[1] = 4'hF;
    rst     = 1'b0;
    step(3);
    rst = 1'b1;
    step(50);
    total = 0;
    for (int u = 0; u < 2; u++)
      for (int k = 0; k < 4; k++)
        for (int c = 0; c < 4; c++) total += cnt[u][k][c];
    chk("idle_events", total, 0);

    // Clean press/release on channel 0
    pb_r[0][0] = 1'b0; t0 = cyc;
    wait_for(0, 0, 0, 20, t);
    chk("press_latency", t - t0, SYNC + DEB);
    chk("press_lvl", int'(lvl_w[0][0]), 1);
    pb_r[0][0] = 1'b1; t0 = cyc;
    wait_for(0, 1, 0, 20, t);
    chk("release_latency", t - t0, 6);
    step(5);

    // Bouncing channel 1
    c0 = cnt[0][0][1];
    for (int i = 0; i < 5; i++) begin
      pb_r[0][1] = 1'b0; step(2);
      pb_r[0][1] = 1'b1; step(2);
    end
    chk("bounce_no_press", cnt[0][0][1] - c0, 0);
    pb_r[0][1] = 1'b0; t0 = cyc;
    wait_for(0, 0, 1, 20, t);
    chk("bounce_settle_latency", t - t0, 6);
    pb_r[0][1] = 1'b1; t0 = cyc;
    wait_for(0, 1, 1, 20, t);
    chk("bounce_release_latency", t - t0, 6);
    chk("bounce_single_press", cnt[0][0][1] - c0, 1);
    step(5);

    // Long press and auto-repeat on channel 2
    rpt_q.delete();
    pb_r[0][2] = 1'b0;
    wait_for(0, 0, 2, 20, t);
    while (cyc < t + 60) step(1);
    pb_r[0][2] = 1'b1;
    wait_for(0, 1, 2, 20, t1);
    step(20);
    chk("lng_delay", last_t[0][2][2] - t, 20);
    chk("rpt_count", rpt_q.size(), 5);
    chk("rpt_first", (rpt_q.size() > 0) ? rpt_q[0] - t : -1, 28);
    chk("rpt_last", (rpt_q.size() > 0) ? rpt_q[rpt_q.size()-1] - t : -1, 60);
    chk("rls_after_hold", t1 - t, 66);

    // Simultaneous press on channels 0 and 3
    pb_r[0][0] = 1'b0; pb_r[0][3] = 1'b0;
    wait_for(0, 0, 0, 20, t);
    chk("simul_prss", last_t[0][0][3], t);
    step(10);
    c0 = cnt[0][1][0];
    pb_r[0][3] = 1'b1;
    wait_for(0, 1, 3, 20, t1);
    chk("rls3_lvl0_held", int'(lvl_w[0][0]), 1);
    chk("rls0_not_fired", cnt[0][1][0] - c0, 0);
    pb_r[0][0] = 1'b1;
    step(30);

    // Reset in the middle of a hold
    pb_r[0][1] = 1'b0;
    wait_for(0, 0, 1, 20, t);
    step(8);
    rst = 1'b0;
    #1;
    chk("async_rst_lvl", int'(lvl_w[0]), 0);
    step(3);
    rst = 1'b1; t0 = cyc;
    wait_for(0, 0, 1, 20, t);
    chk("post_rst_press", t - t0, 6);
    wait_for(0, 2, 1, 40, t1);
    chk("post_rst_lng", t1 - t, 20);
    pb_r[0][1] = 1'b1;
    step(15);

    // Repeat disabled instance
    pb_r[1][0] = 1'b0;
    wait_for(1, 0, 0, 20, t);
    c0 = cnt[1][2][0];
    t0 = cnt[1][3][0];
    step(100);
    chk("norep_lng_count", cnt[1][2][0] - c0, 1);
    chk("norep_rpt_count", cnt[1][3][0] - t0, 0);
    pb_r[1][0] = 1'b1;
    step(15);

    // Random phase: fast chatter, then slow toggling with long holds, plus a reset
    for (int k = 0; k < 700; k++) begin
      for (int u = 0; u < 2; u++)
        for (int c = 0; c < 4; c++)
          if ($urandom_range(0, (k < 300) ? 4 : 45) == 0) pb_r[u][c] = ~pb_r[u][c];
      if (k == 500) rst = 1'b0;
      if (k == 503) rst = 1'b1;
      step(1);
    end
    step(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
